key_event_scheduler: RTL and testbench

KEY_EVENT_SCHEDULER -- requirements
Module: key_event_scheduler

---
 rtl/key_event_scheduler.sv | 136 +++++++++++++
 tb/tb_key_event_scheduler.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/key_event_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : key_event_scheduler
//  Description : Captures single-cycle key press pulses into per-key pending
//                flags, grants one pending key per cycle round-robin into a
//                small in-order event FIFO, and counts lost presses.
//  Revision    : 1.0  initial release
// ============================================================================
module key_event_scheduler #(
    parameter int NKEYS = 5,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NKEYS-1:0] key_pulse,
    input  logic             flush,
    output logic             out_valid,
    output logic [2:0]       out_code,
    input  logic             out_ready,
    output logic [NKEYS-1:0] pending,
    output logic [2:0]       fifo_count,
    output logic [7:0]       drop_count
);

    localparam int         c_PW    = (NKEYS > 1) ? $clog2(NKEYS) : 1;
    localparam int         c_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [2:0] c_DEPTH = 3'(DEPTH);

    logic [NKEYS-1:0] r_pending;
    logic [c_PW-1:0]  r_rr_ptr;
    logic [2:0]       r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [2:0]       r_count;
    logic             r_valid;
    logic [7:0]       r_drop;

    logic             w_pop;
    logic             w_can_push;
    logic             w_grant;
    logic [2:0]       w_gidx;
    logic [NKEYS-1:0] w_gmask;
    logic             w_drop;
    logic [2:0]       w_count_next;

    // A full FIFO can still take a grant when its head leaves on the same edge
    assign w_pop      = (r_count != 3'd0) && out_ready;
    assign w_can_push = (r_count < c_DEPTH) || w_pop;

    // Round-robin search starting at r_rr_ptr; first pending key wins
    always_comb begin
        int idx;
        idx     = 0;
        w_grant = 1'b0;
        w_gidx  = 3'd0;
        for (int k = 0; k < NKEYS; k++) begin
            idx = int'(r_rr_ptr) + k;
            if (idx >= NKEYS) idx = idx - NKEYS;
            if (w_can_push && !w_grant && r_pending[idx]) begin
                w_grant = 1'b1;
                w_gidx  = 3'(idx);
            end
        end
    end

    assign w_gmask = w_grant ? ({{(NKEYS-1){1'b0}}, 1'b1} << w_gidx) : '0;

    // A repeat press on a still-pending key is lost unless that key is granted now
    assign w_drop = |(key_pulse & r_pending & ~w_gmask);

    // Occupancy after this edge, used to register out_valid directly
    always_comb begin
        w_count_next = r_count;
        if (flush) begin
            w_count_next = 3'd0;
        end else if (w_grant && !w_pop) begin
            w_count_next = r_count + 3'd1;
        end else if (!w_grant && w_pop) begin
            w_count_next = r_count - 3'd1;
        end
    end

    // Pending flags, round-robin pointer and saturating drop counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= '0;
            r_rr_ptr  <= '0;
            r_drop    <= 8'd0;
        end else if (flush) begin
            r_pending <= '0;
            r_rr_ptr  <= '0;
        end else begin
            r_pending <= (r_pending & ~w_gmask) | key_pulse;
            if (w_grant) begin
                r_rr_ptr <= (int'(w_gidx) == NKEYS - 1) ? '0 : c_PW'(w_gidx + 3'd1);
            end
            if (w_drop && (r_drop != 8'hFF)) begin
                r_drop <= r_drop + 8'd1;
            end
        end
    end

    // Event FIFO: granted index written at the tail, head popped on accept
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= 3'd0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= 3'd0;
            r_valid  <= 1'b0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= 3'd0;
            r_valid  <= 1'b0;
        end else begin
            if (w_grant) begin
                r_mem[r_wr_ptr] <= w_gidx;
                r_wr_ptr <= (r_wr_ptr == c_AW'(DEPTH - 1)) ? '0 : r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_AW'(DEPTH - 1)) ? '0 : r_rd_ptr + c_AW'(1);
            end
            r_count <= w_count_next;
            r_valid <= (w_count_next != 3'd0);
        end
    end

    assign out_valid  = r_valid;
    assign out_code   = r_mem[r_rd_ptr];
    assign pending    = r_pending;
    assign fifo_count = r_count;
    assign drop_count = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_key_event_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_key_event_scheduler
//  Description : Self-checking bench for key_event_scheduler; directed press
//                scenarios followed by random traffic against a queue model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_key_event_scheduler;

    localparam int c_NK = 5;
    localparam int c_D  = 4;

    logic            clk;
    logic            rst;
    logic [c_NK-1:0] key_pulse;
    logic            flush;
    logic            out_valid;
    logic [2:0]      out_code;
    logic            out_ready;
    logic [c_NK-1:0] pending;
    logic [2:0]      fifo_count;
    logic [7:0]      drop_count;

    key_event_scheduler #(.NKEYS(c_NK), .DEPTH(c_D)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .key_pulse  (key_pulse),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_code   (out_code),
        .out_ready  (out_ready),
        .pending    (pending),
        .fifo_count (fifo_count),
        .drop_count (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [c_NK-1:0] m_pend;
    int              m_rr;
    int              m_q[$];
    int              m_drop;
    bit              m_just_rst;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Apply the rules of one clock edge to the model using the sampled inputs
    task automatic model_edge();
        int              g;
        int              idx;
        bit              pop;
        bit              anydrop;
        logic [c_NK-1:0] np;
        m_just_rst = rst;
        if (rst) begin
            m_pend = '0; m_q.delete(); m_rr = 0; m_drop = 0;
        end else if (flush) begin
            m_pend = '0; m_q.delete(); m_rr = 0;
        end else begin
            pop = (m_q.size() > 0) && out_ready;
            g = -1;
            if (m_q.size() < c_D || pop) begin
                for (int k = 0; k < c_NK; k++) begin
                    idx = (m_rr + k) % c_NK;
                    if (g < 0 && m_pend[idx]) g = idx;
                end
            end
            anydrop = 1'b0;
            for (int i = 0; i < c_NK; i++) begin
                if (key_pulse[i] && m_pend[i] && i != g) anydrop = 1'b1;
                np[i] = key_pulse[i] || (m_pend[i] && i != g);
            end
            if (pop) void'(m_q.pop_front());
            if (g >= 0) begin
                m_q.push_back(g);
                m_rr = (g + 1) % c_NK;
            end
            if (anydrop && m_drop < 255) m_drop++;
            m_pend = np;
        end
    endtask

    task automatic step(input logic [c_NK-1:0] kp, input logic fl, input logic rdy, input logic rs);
        key_pulse = kp; flush = fl; out_ready = rdy; rst = rs;
        @(posedge clk);
        model_edge();
        #1;
        chk("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
        if (m_q.size() != 0) chk("out_code", 32'(out_code), 32'(m_q[0]));
        else if (m_just_rst) chk("out_code_rst", 32'(out_code), 32'd0);
        chk("pending", 32'(pending), 32'(m_pend));
        chk("fifo_count", 32'(fifo_count), 32'(m_q.size()));
        chk("drop_count", 32'(drop_count), 32'(m_drop));
    endtask

    task automatic do_reset();
        step('0, 1'b0, 1'b0, 1'b1);
        step('0, 1'b0, 1'b0, 1'b1);
    endtask

    // Three queued keys (2,3,4) and pending = 00011, with out_ready low
    task automatic build_three();
        step(5'b00100, 1'b0, 1'b0, 1'b0);
        step(5'b01000, 1'b0, 1'b0, 1'b0);
        step(5'b10000, 1'b0, 1'b0, 1'b0);
        step(5'b00011, 1'b0, 1'b0, 1'b0);
        chk("build_count", 32'(fifo_count), 32'd3);
        chk("build_pend", 32'(pending), 32'b00011);
    endtask

    initial begin
        key_pulse = '0; flush = 1'b0; out_ready = 1'b0; rst = 1'b1;
        m_pend = '0; m_rr = 0; m_drop = 0; m_just_rst = 1'b0;

        // Single press
        do_reset();
        step(5'b00100, 1'b0, 1'b1, 1'b0);
        chk("single_wait", 32'(out_valid), 32'd0);
        step('0, 1'b0, 1'b1, 1'b0);
        chk("single_valid", 32'(out_valid), 32'd1);
        chk("single_code", 32'(out_code), 32'd2);
        step('0, 1'b0, 1'b1, 1'b0);
        chk("single_gone", 32'(out_valid), 32'd0);
        chk("single_drop", 32'(drop_count), 32'd0);

        // All keys at once: drained in index order on consecutive cycles
        do_reset();
        step(5'b11111, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < c_NK; k++) begin
            step('0, 1'b0, 1'b1, 1'b0);
            chk("simul_seq", 32'(out_code), 32'(k));
        end
        chk("simul_pend", 32'(pending), 32'd0);

        // Back-pressure then release
        do_reset();
        for (int i = 0; i < c_NK; i++) step(5'(1 << i), 1'b0, 1'b0, 1'b0);
        step('0, 1'b0, 1'b0, 1'b0);
        chk("bp_count", 32'(fifo_count), 32'd4);
        chk("bp_pend", 32'(pending), 32'b10000);
        for (int k = 0; k < c_NK; k++) begin
            chk("bp_seq", 32'(out_code), 32'(k));
            step('0, 1'b0, 1'b1, 1'b0);
        end

        // Drops on a full FIFO, then saturation
        do_reset();
        step(5'b00001, 1'b0, 1'b0, 1'b0);
        step(5'b00100, 1'b0, 1'b0, 1'b0);
        step(5'b01000, 1'b0, 1'b0, 1'b0);
        step(5'b10000, 1'b0, 1'b0, 1'b0);
        step('0, 1'b0, 1'b0, 1'b0);
        step(5'b00010, 1'b0, 1'b0, 1'b0);
        chk("drop_none", 32'(drop_count), 32'd0);
        step(5'b00010, 1'b0, 1'b0, 1'b0);
        chk("drop_one", 32'(drop_count), 32'd1);
        chk("drop_pend", 32'(pending[1]), 32'd1);
        for (int r = 0; r < 299; r++) step(5'b00010, 1'b0, 1'b0, 1'b0);
        chk("drop_sat", 32'(drop_count), 32'd255);

        // Flush keeps drop_count; reset clears it
        step('0, 1'b1, 1'b0, 1'b0);
        build_three();
        step(5'b11111, 1'b1, 1'b1, 1'b0);
        chk("flush_count", 32'(fifo_count), 32'd0);
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_pend", 32'(pending), 32'd0);
        chk("flush_drop", 32'(drop_count), 32'd255);
        build_three();
        step(5'b11111, 1'b1, 1'b1, 1'b1);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_drop", 32'(drop_count), 32'd0);

        // Random traffic
        for (int n = 0; n < 4000; n++) begin
            logic [c_NK-1:0] kp;
            kp = ($urandom_range(0, 2) == 0) ? 5'($urandom) : '0;
            step(kp,
                 ($urandom_range(0, 59) == 0),
                 ($urandom_range(0, 3) != 0) && ((n / 100) % 3 != 2),
                 ($urandom_range(0, 399) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
